ibex_fp_issue: RTL and testbench

//  Upstream issue stage of ibex_FPU. It owns the 32x32 FP register file and a per-register

---
 rtl/ibex_fp_pkg.sv | 74 +++++++
 rtl/ibex_fp_scoreboard.sv | 89 ++++++++
 rtl/ibex_fp_issue.sv | 159 +++++++++++++++
 tb/tb_ibex_fp_issue.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_fp_pkg.sv
// ---------------------------------------------------------------------------
// ibex_fp_pkg
//   Shared types for the FP issue stage:
//     fpu_op_e      FP operation encoding presented to ibex_FPU
//     fp_op_srcs_t  which operands an op reads and where its result goes
//     fp_op_srcs()  decode of fpu_op_e into fp_op_srcs_t
//     RM_DYN        rounding-mode encoding that selects the CSR frm value
//     rm_is_reserved() true for the two reserved rounding modes
// ---------------------------------------------------------------------------
package ibex_fp_pkg;

  typedef enum logic [3:0] {
    FPU_NOP     = 4'd0,
    FPU_ADD     = 4'd1,
    FPU_SUB     = 4'd2,
    FPU_MUL     = 4'd3,
    FPU_DIV     = 4'd4,
    FPU_SQRT    = 4'd5,
    FPU_FMADD   = 4'd6,
    FPU_FEQ     = 4'd7,
    FPU_CVT_W_S = 4'd8,
    FPU_MV_X_W  = 4'd9,
    FPU_CVT_S_W = 4'd10,
    FPU_MV_W_X  = 4'd11
  } fpu_op_e;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rs3;
    logic rs1_is_int;  // rs1 comes from the integer side, not the FP regfile
    logic rd_is_fp;    // result is written to the FP regfile
  } fp_op_srcs_t;

  localparam logic [2:0] RM_DYN = 3'b111;

  function automatic fp_op_srcs_t fp_op_srcs(input fpu_op_e op);
    fp_op_srcs_t s;
    s = '0;
    case (op)
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV: begin
        s.uses_rs1 = 1'b1;
        s.uses_rs2 = 1'b1;
        s.rd_is_fp = 1'b1;
      end
      FPU_SQRT: begin
        s.uses_rs1 = 1'b1;
        s.rd_is_fp = 1'b1;
      end
      FPU_FMADD: begin
        s.uses_rs1 = 1'b1;
        s.uses_rs2 = 1'b1;
        s.uses_rs3 = 1'b1;
        s.rd_is_fp = 1'b1;
      end
      FPU_FEQ: begin
        s.uses_rs1 = 1'b1;
        s.uses_rs2 = 1'b1;
      end
      FPU_CVT_W_S, FPU_MV_X_W: s.uses_rs1 = 1'b1;
      FPU_CVT_S_W, FPU_MV_W_X: begin
        s.rs1_is_int = 1'b1;
        s.rd_is_fp   = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic rm_is_reserved(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110);
  endfunction

endpackage

// File: rtl/ibex_fp_scoreboard.sv
// ---------------------------------------------------------------------------
// ibex_fp_scoreboard
//   Per-register pending bits, RAW/WAW hazard detection and the count of ops
//   handed to the FPU that have not yet written back.
//   Ports:
//     clk_i, rst_i            clock, synchronous active-high reset
//     set_en_i/set_addr_i     mark a destination register pending (wins over clear)
//     clr_en_i/clr_addr_i     FP writeback clears the pending bit
//     srcs_i, rs*_addr_i,
//     rd_addr_i               operand usage and addresses of the candidate op
//     inc_i / dec_i           FPU handshake / any FPU writeback
//     out_valid_i             issue output register currently holds an op
//     hazard_o                candidate op must stall on a pending register
//     cap_ok_o                room for one more op in flight
//     inflight_cnt_o          ops issued to the FPU and not yet written back
// ---------------------------------------------------------------------------
module ibex_fp_scoreboard
  import ibex_fp_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en_i,
  input  logic [4:0]       set_addr_i,
  input  logic             clr_en_i,
  input  logic [4:0]       clr_addr_i,
  input  fp_op_srcs_t      srcs_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic [4:0]       rs3_addr_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             out_valid_i,
  output logic             hazard_o,
  output logic             cap_ok_o,
  output logic [CNT_W-1:0] inflight_cnt_o
);

  logic [31:0] sb_q;
  logic [31:0] clr_vec;
  logic [31:0] set_vec;
  logic [31:0] pend_eff;

  assign clr_vec = clr_en_i ? (32'd1 << clr_addr_i) : '0;
  assign set_vec = set_en_i ? (32'd1 << set_addr_i) : '0;

  // A register being written back this cycle is already safe to read (bypass)
  // and to overwrite, so it no longer blocks the candidate op.
  assign pend_eff = sb_q & ~clr_vec;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    hazard_o = 1'b0;
    if (srcs_i.uses_rs1 && !srcs_i.rs1_is_int && pend_eff[rs1_addr_i]) hazard_o = 1'b1;
    if (srcs_i.uses_rs2 && pend_eff[rs2_addr_i])                       hazard_o = 1'b1;
    if (srcs_i.uses_rs3 && pend_eff[rs3_addr_i])                       hazard_o = 1'b1;
    if (srcs_i.rd_is_fp && pend_eff[rd_addr_i])                        hazard_o = 1'b1;
  end

  // The op sitting in the output register will enter the FPU, so it counts
  // against the in-flight budget already.
  assign cap_ok_o = ({1'b0, inflight_cnt_o} + (CNT_W + 1)'(out_valid_i))
                    < (CNT_W + 1)'(MAX_INFLIGHT);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q <= '0;
    end else begin
      sb_q <= (sb_q & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_cnt_o <= '0;
    end else if (inc_i && !dec_i) begin
      inflight_cnt_o <= inflight_cnt_o + 1'b1;
    end else if (dec_i && !inc_i && (inflight_cnt_o != '0)) begin
      inflight_cnt_o <= inflight_cnt_o - 1'b1;
    end
  end

endmodule

// File: rtl/ibex_fp_issue.sv
// ---------------------------------------------------------------------------
// ibex_fp_issue
//   Issue stage in front of ibex_FPU: owns the 32x32 FP regfile, checks
//   operands against the pending scoreboard, reads them with bypass from FPU
//   writeback and hands the op to the FPU through a one-entry output register.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     instr_valid_i/instr_ready_o  decoded op handshake
//     fp_op_i, rs1..3_addr_i,
//     rd_addr_i, rm_i, frm_i,
//     rs1_int_i                    decoded op fields, CSR frm, integer operand
//     fpu_valid_o/fpu_ready_i      handshake towards the FPU
//     fp_op_o, rs1..3_o, rs1_int_o,
//     rd_addr_o, rm_o              held op presented to the FPU
//     fp_wb_en_i/addr/data         FPU writes an FP register
//     int_wb_en_i                  FPU finished an integer-destination op
//     illegal_rm_o                 pulse: an accepted op carried a reserved rm
//     busy_o                       ops in flight or held for the FPU
// ---------------------------------------------------------------------------
module ibex_fp_issue
  import ibex_fp_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  fpu_op_e     fp_op_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rs3_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [2:0]  rm_i,
  input  logic [2:0]  frm_i,
  input  logic [31:0] rs1_int_i,
  output logic        fpu_valid_o,
  input  logic        fpu_ready_i,
  output fpu_op_e     fp_op_o,
  output logic [31:0] rs1_o,
  output logic [31:0] rs2_o,
  output logic [31:0] rs3_o,
  output logic [31:0] rs1_int_o,
  output logic [4:0]  rd_addr_o,
  output logic [2:0]  rm_o,
  input  logic        fp_wb_en_i,
  input  logic [4:0]  fp_wb_addr_i,
  input  logic [31:0] fp_wb_data_i,
  input  logic        int_wb_en_i,
  output logic        illegal_rm_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [31:0]      regfile_q [32];
  fp_op_srcs_t      srcs;
  logic             hazard;
  logic             cap_ok;
  logic [CNT_W-1:0] inflight_cnt;
  logic             slot_free;
  logic             accept;
  logic             issue;
  logic             rm_bad;
  logic [2:0]       rm_res;
  logic             fpu_hs;
  logic [31:0]      rs1_byp;
  logic [31:0]      rs2_byp;
  logic [31:0]      rs3_byp;

  assign srcs      = fp_op_srcs(fp_op_i);
  assign fpu_hs    = fpu_valid_o && fpu_ready_i;
  assign slot_free = !fpu_valid_o || fpu_ready_i;

  assign instr_ready_o = !rst_i && slot_free && !hazard && cap_ok;
  assign accept        = instr_valid_i && instr_ready_o;

  // A reserved rounding mode consumes the op without issuing it.
  assign rm_res = (rm_i == RM_DYN) ? frm_i : rm_i;
  assign rm_bad = rm_is_reserved(rm_res);
  assign issue  = accept && !rm_bad;

  assign busy_o = (inflight_cnt != '0) || fpu_valid_o;

  ibex_fp_scoreboard #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_scoreboard (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .set_en_i       (issue && srcs.rd_is_fp),
    .set_addr_i     (rd_addr_i),
    .clr_en_i       (fp_wb_en_i),
    .clr_addr_i     (fp_wb_addr_i),
    .srcs_i         (srcs),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rs3_addr_i     (rs3_addr_i),
    .rd_addr_i      (rd_addr_i),
    .inc_i          (fpu_hs),
    .dec_i          (fp_wb_en_i || int_wb_en_i),
    .out_valid_i    (fpu_valid_o),
    .hazard_o       (hazard),
    .cap_ok_o       (cap_ok),
    .inflight_cnt_o (inflight_cnt)
  );

  // Same-cycle writeback data is forwarded so a dependent op can be accepted
  // in the very cycle its producer writes back.
  assign rs1_byp = (fp_wb_en_i && fp_wb_addr_i == rs1_addr_i) ? fp_wb_data_i : regfile_q[rs1_addr_i];
  assign rs2_byp = (fp_wb_en_i && fp_wb_addr_i == rs2_addr_i) ? fp_wb_data_i : regfile_q[rs2_addr_i];
  assign rs3_byp = (fp_wb_en_i && fp_wb_addr_i == rs3_addr_i) ? fp_wb_data_i : regfile_q[rs3_addr_i];

  // NOTE: the regfile is deliberately reset: after a reset every register must
  // read as zero, so this array is built from resettable flops, not a RAM macro.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regfile_q[i] <= '0;
    end else if (fp_wb_en_i) begin
      regfile_q[fp_wb_addr_i] <= fp_wb_data_i;
    end
  end

  // Output register: loads on issue, otherwise holds its contents; valid drops
  // once the FPU has taken the op and nothing new replaced it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpu_valid_o  <= 1'b0;
      fp_op_o      <= FPU_NOP;
      rs1_o        <= '0;
      rs2_o        <= '0;
      rs3_o        <= '0;
      rs1_int_o    <= '0;
      rd_addr_o    <= '0;
      rm_o         <= '0;
      illegal_rm_o <= 1'b0;
    end else begin
      illegal_rm_o <= accept && rm_bad;
      if (issue) begin
        fpu_valid_o <= 1'b1;
        fp_op_o     <= fp_op_i;
        rs1_o       <= rs1_byp;
        rs2_o       <= rs2_byp;
        rs3_o       <= rs3_byp;
        rs1_int_o   <= rs1_int_i;
        rd_addr_o   <= rd_addr_i;
        rm_o        <= rm_res;
      end else if (fpu_ready_i) begin
        fpu_valid_o <= 1'b0;
      end
    end
  end

  // An integer writeback always retires an op previously taken by the FPU, so
  // one arriving with nothing in flight means the FPU handshake is broken. FP
  // writebacks also serve to load registers directly and may arrive at zero.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   (int_wb_en_i && !fpu_hs) |-> (inflight_cnt != '0));

endmodule

// File: tb/tb_ibex_fp_issue.sv
module tb_ibex_fp_issue;
  import ibex_fp_pkg::*;

  localparam int MAX_INFLIGHT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  fpu_op_e     fp_op_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rs3_addr_i, rd_addr_i;
  logic [2:0]  rm_i, frm_i;
  logic [31:0] rs1_int_i;
  logic        fpu_valid_o;
  logic        fpu_ready_i;
  fpu_op_e     fp_op_o;
  logic [31:0] rs1_o, rs2_o, rs3_o, rs1_int_o;
  logic [4:0]  rd_addr_o;
  logic [2:0]  rm_o;
  logic        fp_wb_en_i;
  logic [4:0]  fp_wb_addr_i;
  logic [31:0] fp_wb_data_i;
  logic        int_wb_en_i;
  logic        illegal_rm_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  ibex_fp_issue #(.MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .fp_op_i(fp_op_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs3_addr_i(rs3_addr_i), .rd_addr_i(rd_addr_i), .rm_i(rm_i), .frm_i(frm_i),
    .rs1_int_i(rs1_int_i), .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
    .fp_op_o(fp_op_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rs3_o(rs3_o),
    .rs1_int_o(rs1_int_o), .rd_addr_o(rd_addr_o), .rm_o(rm_o),
    .fp_wb_en_i(fp_wb_en_i), .fp_wb_addr_i(fp_wb_addr_i), .fp_wb_data_i(fp_wb_data_i),
    .int_wb_en_i(int_wb_en_i), .illegal_rm_o(illegal_rm_o), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  bit   [31:0] m_pend;
  int          m_cnt;
  bit          m_valid, m_ill;
  fpu_op_e     m_op;
  logic [31:0] m_rs1, m_rs2, m_rs3, m_int;
  logic [4:0]  m_rd;
  logic [2:0]  m_rm;

  typedef struct { bit is_fp; logic [4:0] rd; } cmpl_t;
  cmpl_t done_q[$];

  // {reads rs1, reads rs2, reads rs3, writes an FP register}
  function automatic logic [3:0] m_uses(input fpu_op_e op);
    case (op)
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV: return 4'b1101;
      FPU_SQRT:                           return 4'b1001;
      FPU_FMADD:                          return 4'b1111;
      FPU_FEQ:                            return 4'b1100;
      FPU_CVT_W_S, FPU_MV_X_W:            return 4'b1000;
      FPU_CVT_S_W, FPU_MV_W_X:            return 4'b0001;
      default:                            return 4'b0000;
    endcase
  endfunction

  function automatic bit m_blocked(input logic [4:0] r);
    return m_pend[r] && !(fp_wb_en_i && fp_wb_addr_i == r);
  endfunction

  function automatic bit model_ready();
    logic [3:0] u;
    bit haz;
    u = m_uses(fp_op_i);
    haz = (u[3] && m_blocked(rs1_addr_i)) || (u[2] && m_blocked(rs2_addr_i)) ||
          (u[1] && m_blocked(rs3_addr_i)) || (u[0] && m_blocked(rd_addr_i));
    return !rst_i && (!m_valid || fpu_ready_i) && !haz && (m_cnt + int'(m_valid) < MAX_INFLIGHT);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (fp_wb_en_i && fp_wb_addr_i == a) ? fp_wb_data_i : m_rf[a];
  endfunction

  // Advance the model by one clock using the currently driven inputs, then
  // step the DUT and land 1ns after the edge.
  task automatic tick();
    bit acc, bad, hs, dec;
    logic [2:0] rr;
    logic [3:0] u, u_held;
    cmpl_t e;
    acc = instr_valid_i && model_ready();
    rr  = (rm_i == 3'b111) ? frm_i : rm_i;
    bad = (rr == 3'b101) || (rr == 3'b110);
    hs  = m_valid && fpu_ready_i;
    dec = fp_wb_en_i || int_wb_en_i;
    u   = m_uses(fp_op_i);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_pend = '0; m_cnt = 0; m_valid = 0; m_ill = 0; m_op = FPU_NOP;
      m_rs1 = '0; m_rs2 = '0; m_rs3 = '0; m_int = '0; m_rd = '0; m_rm = '0;
      done_q.delete();
    end else begin
      if (hs) begin
        u_held = m_uses(m_op);
        e.is_fp = u_held[0];
        e.rd = m_rd;
        done_q.push_back(e);
      end
      if (hs && !dec) m_cnt++;
      else if (dec && !hs && m_cnt > 0) m_cnt--;
      if (acc && !bad) begin
        m_op = fp_op_i; m_rs1 = m_read(rs1_addr_i); m_rs2 = m_read(rs2_addr_i);
        m_rs3 = m_read(rs3_addr_i); m_int = rs1_int_i; m_rd = rd_addr_i; m_rm = rr;
        m_valid = 1;
      end else if (fpu_ready_i) begin
        m_valid = 0;
      end
      if (fp_wb_en_i) begin
        m_rf[fp_wb_addr_i] = fp_wb_data_i;
        m_pend[fp_wb_addr_i] = 0;
      end
      if (acc && !bad && u[0]) m_pend[rd_addr_i] = 1;
      m_ill = acc && bad;
    end
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    instr_valid_i = 0; fp_op_i = FPU_NOP; rs1_addr_i = 0; rs2_addr_i = 0; rs3_addr_i = 0;
    rd_addr_i = 0; rm_i = 0; frm_i = 0; rs1_int_i = 0; fpu_ready_i = 1;
    fp_wb_en_i = 0; fp_wb_addr_i = 0; fp_wb_data_i = 0; int_wb_en_i = 0;
  endtask

  task automatic drive_op(input fpu_op_e op, input logic [4:0] rd, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [2:0] rm);
    instr_valid_i = 1; fp_op_i = op; rd_addr_i = rd; rs1_addr_i = a1; rs2_addr_i = a2;
    rs3_addr_i = 0; rm_i = rm;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    fp_wb_en_i = 1; fp_wb_addr_i = a; fp_wb_data_i = d;
    tick();
    fp_wb_en_i = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst_i = 1;
    tick();
    tick();
    n_cmp++; if (instr_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", instr_ready_o); end
    n_cmp++; if ({fpu_valid_o, illegal_rm_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {fpu_valid_o, illegal_rm_o, busy_o}); end
    n_cmp++; if (fp_op_o !== FPU_NOP) begin n_err++; $display("FAIL reset_op: got %0d want %0d", fp_op_o, FPU_NOP); end
    n_cmp++; if ({rs1_o, rs2_o, rs3_o, rs1_int_o, rd_addr_o, rm_o} !== '0) begin n_err++; $display("FAIL reset_data: outputs not zero (rs1 %h rd %h)", rs1_o, rd_addr_o); end
    rst_i = 0;
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", instr_ready_o); end
  endtask

  task automatic test_basic();
    idle();
    wb(5'd1, 32'h4023d70a);
    wb(5'd2, 32'h41200000);
    fpu_ready_i = 0;
    drive_op(FPU_ADD, 5'd3, 5'd1, 5'd2, 3'b000);
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", instr_ready_o); end
    tick();
    instr_valid_i = 0;
    n_cmp++; if (fpu_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", fpu_valid_o); end
    n_cmp++; if ({rs1_o, rs2_o} !== {32'h4023d70a, 32'h41200000}) begin n_err++; $display("FAIL basic_operands: got %h %h want 4023d70a 41200000", rs1_o, rs2_o); end
    n_cmp++; if ({fp_op_o, rd_addr_o} !== {FPU_ADD, 5'd3}) begin n_err++; $display("FAIL basic_op_rd: got %0d %0d want %0d 3", fp_op_o, rd_addr_o, FPU_ADD); end
    // f3 is now pending: a reader of f3 stalls even with a free slot.
    fpu_ready_i = 1;
    drive_op(FPU_SQRT, 5'd20, 5'd3, 5'd0, 3'b000);
    instr_valid_i = 0;
    #1;
    n_cmp++; if (instr_ready_o !== 1'b0) begin n_err++; $display("FAIL basic_sb3_stall: got %b want 0", instr_ready_o); end
    tick();
    n_cmp++; if (fpu_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", fpu_valid_o); end
    idle();
    wb(5'd3, 32'h414a3d71);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_idle: busy got %b want 0", busy_o); end
  endtask

  task automatic test_raw_bypass();
    idle();
    drive_op(FPU_ADD, 5'd3, 5'd1, 5'd2, 3'b000);
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL raw_add_ready: got %b want 1", instr_ready_o); end
    tick();
    drive_op(FPU_MUL, 5'd4, 5'd3, 5'd2, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (instr_ready_o !== 1'b0) begin n_err++; $display("FAIL raw_stall_%0d: got %b want 0", i, instr_ready_o); end
      tick();
    end
    fp_wb_en_i = 1; fp_wb_addr_i = 5'd3; fp_wb_data_i = 32'h414a3d71;
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL raw_wb_ready: got %b want 1", instr_ready_o); end
    tick();
    idle();
    n_cmp++; if ({fpu_valid_o, fp_op_o} !== {1'b1, FPU_MUL}) begin n_err++; $display("FAIL raw_issue: got %b %0d want 1 %0d", fpu_valid_o, fp_op_o, FPU_MUL); end
    n_cmp++; if ({rs1_o, rs2_o} !== {32'h414a3d71, 32'h41200000}) begin n_err++; $display("FAIL raw_bypass: got %h %h want 414a3d71 41200000", rs1_o, rs2_o); end
    tick();
    wb(5'd4, 32'h427ce148);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL raw_idle: busy got %b want 0", busy_o); end
  endtask

  task automatic test_hold();
    idle();
    fpu_ready_i = 0;
    drive_op(FPU_ADD, 5'd5, 5'd1, 5'd2, 3'b010);
    tick();
    drive_op(FPU_SUB, 5'd6, 5'd2, 5'd1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (instr_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_ready_%0d: got %b want 0", i, instr_ready_o); end
      n_cmp++; if ({fpu_valid_o, fp_op_o, rd_addr_o, rm_o, rs1_o, rs2_o} !== {1'b1, FPU_ADD, 5'd5, 3'b010, 32'h4023d70a, 32'h41200000}) begin
        n_err++; $display("FAIL hold_stable_%0d: got v%b op%0d rd%0d rm%0d %h %h", i, fpu_valid_o, fp_op_o, rd_addr_o, rm_o, rs1_o, rs2_o);
      end
      tick();
    end
    fpu_ready_i = 1;
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %b want 1", instr_ready_o); end
    tick();
    instr_valid_i = 0;
    n_cmp++; if ({fpu_valid_o, fp_op_o, rd_addr_o, rs1_o} !== {1'b1, FPU_SUB, 5'd6, 32'h41200000}) begin
      n_err++; $display("FAIL hold_second: got v%b op%0d rd%0d rs1 %h", fpu_valid_o, fp_op_o, rd_addr_o, rs1_o);
    end
    tick();
    wb(5'd5, 32'h41513d71);
    wb(5'd6, 32'h40bb851f);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL hold_idle: busy got %b want 0", busy_o); end
  endtask

  task automatic test_capacity();
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_op(FPU_ADD, 5'(7 + i), 5'd1, 5'd2, 3'b000);
      #1;
      n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL cap_issue_%0d: got %b want 1", i, instr_ready_o); end
      tick();
    end
    drive_op(FPU_FEQ, 5'd12, 5'd1, 5'd2, 3'b000);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (instr_ready_o !== 1'b0) begin n_err++; $display("FAIL cap_stall_%0d: got %b want 0", i, instr_ready_o); end
      tick();
    end
    int_wb_en_i = 1;
    #1;
    n_cmp++; if (instr_ready_o !== 1'b0) begin n_err++; $display("FAIL cap_pulse_cycle: got %b want 0", instr_ready_o); end
    tick();
    int_wb_en_i = 0;
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL cap_after_pulse: got %b want 1", instr_ready_o); end
    tick();
    instr_valid_i = 0;
    tick();
    #1;
    n_cmp++; if ({instr_ready_o, busy_o} !== 2'b01) begin n_err++; $display("FAIL cap_full_again: ready/busy got %b want 01", {instr_ready_o, busy_o}); end
    for (int i = 0; i < 4; i++) wb(5'(7 + i), 32'h41000000 + 32'(i));
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL cap_drained: busy got %b want 0", busy_o); end
  endtask

  task automatic test_rm();
    idle();
    frm_i = 3'b001;
    drive_op(FPU_ADD, 5'd11, 5'd1, 5'd2, 3'b111);
    tick();
    instr_valid_i = 0;
    n_cmp++; if ({fpu_valid_o, rm_o, illegal_rm_o} !== {1'b1, 3'b001, 1'b0}) begin n_err++; $display("FAIL rm_dynamic: got v%b rm%b ill%b want 1 001 0", fpu_valid_o, rm_o, illegal_rm_o); end
    tick();
    wb(5'd11, 32'h3f800000);
    drive_op(FPU_ADD, 5'd12, 5'd1, 5'd2, 3'b101);
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL rm_bad_ready: got %b want 1", instr_ready_o); end
    tick();
    instr_valid_i = 0;
    n_cmp++; if ({illegal_rm_o, fpu_valid_o, busy_o} !== 3'b100) begin n_err++; $display("FAIL rm_bad_consume: ill/valid/busy got %b want 100", {illegal_rm_o, fpu_valid_o, busy_o}); end
    drive_op(FPU_SQRT, 5'd13, 5'd12, 5'd0, 3'b000);
    instr_valid_i = 0;
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL rm_bad_sb_clean: got %b want 1", instr_ready_o); end
    tick();
    n_cmp++; if (illegal_rm_o !== 1'b0) begin n_err++; $display("FAIL rm_pulse_once: got %b want 0", illegal_rm_o); end
    frm_i = 3'b110;
    drive_op(FPU_MUL, 5'd12, 5'd1, 5'd2, 3'b111);
    tick();
    instr_valid_i = 0;
    n_cmp++; if ({illegal_rm_o, fpu_valid_o} !== 2'b10) begin n_err++; $display("FAIL rm_dyn_reserved: ill/valid got %b want 10", {illegal_rm_o, fpu_valid_o}); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    fpu_ready_i = 0;
    drive_op(FPU_ADD, 5'd3, 5'd1, 5'd2, 3'b000);
    tick();
    instr_valid_i = 0;
    n_cmp++; if (fpu_valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_held: got %b want 1", fpu_valid_o); end
    rst_i = 1;
    tick();
    rst_i = 0;
    n_cmp++; if ({fpu_valid_o, busy_o, rs1_o} !== {2'b00, 32'h0}) begin n_err++; $display("FAIL rstmid_clear: v%b busy%b rs1 %h", fpu_valid_o, busy_o, rs1_o); end
    n_cmp++; if (fp_op_o !== FPU_NOP) begin n_err++; $display("FAIL rstmid_op: got %0d want %0d", fp_op_o, FPU_NOP); end
    fpu_ready_i = 1;
    drive_op(FPU_ADD, 5'd3, 5'd3, 5'd1, 3'b000);
    #1;
    n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_sb_clear: got %b want 1", instr_ready_o); end
    tick();
    instr_valid_i = 0;
    n_cmp++; if ({rs1_o, rs2_o} !== 64'h0) begin n_err++; $display("FAIL rstmid_rf_zero: got %h %h want 0 0", rs1_o, rs2_o); end
    tick();
    wb(5'd3, 32'h0);
  endtask

  task automatic test_random();
    int idx;
    cmpl_t e;
    idle();
    rst_i = 1;
    tick();
    rst_i = 0;
    for (int c = 0; c < 800; c++) begin
      instr_valid_i = ($urandom_range(0, 3) != 0);
      fp_op_i       = fpu_op_e'(4'($urandom_range(0, 11)));
      rs1_addr_i    = 5'($urandom_range(0, 7));
      rs2_addr_i    = 5'($urandom_range(0, 7));
      rs3_addr_i    = 5'($urandom_range(0, 7));
      rd_addr_i     = 5'($urandom_range(0, 7));
      rm_i          = 3'($urandom_range(0, 7));
      frm_i         = 3'($urandom_range(0, 4));
      rs1_int_i     = $urandom;
      fpu_ready_i   = ($urandom_range(0, 3) != 0);
      fp_wb_en_i = 0; int_wb_en_i = 0; fp_wb_addr_i = 0; fp_wb_data_i = 0;
      if (done_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, done_q.size() - 1);
        e = done_q[idx];
        done_q.delete(idx);
        if (e.is_fp) begin
          fp_wb_en_i = 1; fp_wb_addr_i = e.rd; fp_wb_data_i = $urandom;
        end else begin
          int_wb_en_i = 1;
        end
      end
      rst_i = ($urandom_range(0, 299) == 0);
      #1;
      n_cmp++; if (instr_ready_o !== model_ready()) begin n_err++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, instr_ready_o, model_ready()); end
      tick();
      n_cmp++; if ({fpu_valid_o, illegal_rm_o, busy_o} !== {m_valid, m_ill, (m_cnt != 0) || m_valid}) begin
        n_err++; $display("FAIL rand_flags cycle %0d: got %b want %b", c, {fpu_valid_o, illegal_rm_o, busy_o}, {m_valid, m_ill, (m_cnt != 0) || m_valid});
      end
      if (m_valid) begin
        n_cmp++; if ({fp_op_o, rs1_o, rs2_o, rs3_o, rs1_int_o, rd_addr_o, rm_o} !== {m_op, m_rs1, m_rs2, m_rs3, m_int, m_rd, m_rm}) begin
          n_err++; $display("FAIL rand_payload cycle %0d: got op%0d %h %h %h %h rd%0d rm%0d want op%0d %h %h %h %h rd%0d rm%0d",
                            c, fp_op_o, rs1_o, rs2_o, rs3_o, rs1_int_o, rd_addr_o, rm_o,
                            m_op, m_rs1, m_rs2, m_rs3, m_int, m_rd, m_rm);
        end
      end
    end
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1;
    idle();
    test_reset();
    test_basic();
    test_raw_bypass();
    test_hold();
    test_capacity();
    test_rm();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
